// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with one-entry skid buffer
// Optional feature: define FETCH_PERF_CNT_EN to build the fetch/stall performance counters.
module fetch_ctrl #(
   parameter logic [31:0] PC_START = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   typedef enum logic [1:0] {IDLE, REQ, SKID, DROP} state_t;

   state_t      state, state_nxt;
   logic [31:0] fetch_pc, fetch_pc_nxt;
   logic [31:0] drop_addr, drop_addr_nxt;
   logic        skid_valid, skid_valid_nxt;
   logic [31:0] skid_instr, skid_instr_nxt;
   logic [31:0] skid_pc, skid_pc_nxt;
   logic        out_valid_nxt;
   logic [31:0] instr_nxt, instr_pc_nxt;
   logic        consume;
   logic [31:0] redirect_tgt;

   assign consume      = instr_valid & ~stall;
   assign redirect_tgt = {redirect_pc[31:2], 2'b00};

   // Memory request is driven only while a fetch (or a stale fetch being drained) is outstanding
   assign imem_req  = (state == REQ) || (state == DROP);
   assign imem_addr = (state == DROP) ? drop_addr : fetch_pc;

   // Next-state and datapath selection; redirect overrides everything else
   always_comb begin
      state_nxt      = state;
      fetch_pc_nxt   = fetch_pc;
      drop_addr_nxt  = drop_addr;
      skid_valid_nxt = skid_valid;
      skid_instr_nxt = skid_instr;
      skid_pc_nxt    = skid_pc;
      out_valid_nxt  = instr_valid;
      instr_nxt      = instr;
      instr_pc_nxt   = instr_pc;

      if (consume) begin
         out_valid_nxt = 1'b0;
      end

      case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            if (imem_ack) begin
               fetch_pc_nxt = fetch_pc + 32'd4;
               if (!instr_valid || !stall) begin
                  out_valid_nxt = 1'b1;
                  instr_nxt     = imem_rdata;
                  instr_pc_nxt  = fetch_pc;
               end else begin
                  skid_valid_nxt = 1'b1;
                  skid_instr_nxt = imem_rdata;
                  skid_pc_nxt    = fetch_pc;
                  state_nxt      = SKID;
               end
            end
         end
         SKID: begin
            if (consume) begin
               out_valid_nxt  = 1'b1;
               instr_nxt      = skid_instr;
               instr_pc_nxt   = skid_pc;
               skid_valid_nxt = 1'b0;
               state_nxt      = REQ;
            end
         end
         DROP: begin
            if (imem_ack) begin
               state_nxt = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (redirect) begin
         out_valid_nxt  = 1'b0;
         skid_valid_nxt = 1'b0;
         fetch_pc_nxt   = redirect_tgt;
         case (state)
            REQ: begin
               // An unanswered request must still be drained at its original address
               if (imem_ack) begin
                  state_nxt = REQ;
               end else begin
                  state_nxt     = DROP;
                  drop_addr_nxt = fetch_pc;
               end
            end
            // The stale address is kept; an ack on this edge still completes the stale request
            DROP:    state_nxt = imem_ack ? REQ : DROP;
            default: state_nxt = REQ;
         endcase
      end
   end

   // State, fetch address, skid buffer and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         fetch_pc    <= PC_START;
         drop_addr   <= PC_START;
         skid_valid  <= 1'b0;
         skid_instr  <= 32'd0;
         skid_pc     <= 32'd0;
         instr_valid <= 1'b0;
         instr       <= 32'd0;
         instr_pc    <= 32'd0;
      end else begin
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         drop_addr   <= drop_addr_nxt;
         skid_valid  <= skid_valid_nxt;
         skid_instr  <= skid_instr_nxt;
         skid_pc     <= skid_pc_nxt;
         instr_valid <= out_valid_nxt;
         instr       <= instr_nxt;
         instr_pc    <= instr_pc_nxt;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Delivered-instruction and stalled-cycle counters, free-running with wrap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (consume) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (instr_valid && stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`else
   assign fetch_cnt = 32'd0;
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard testbench for fetch_ctrl
module tb_fetch_ctrl;

   localparam logic [31:0] PC_START = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   always #5 clk = ~clk;

   fetch_ctrl #(.PC_START(PC_START)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instr_valid(instr_valid),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .fetch_cnt  (fetch_cnt),
      .stall_cnt  (stall_cnt)
   );

   // Instruction memory contents as a function of address
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   assign imem_rdata = imem_ack ? mem_f(imem_addr) : 32'hDEAD_BEEF;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } item_t;

   // Reference model: instructions held downstream-visible, in delivery order
   item_t       q[$];
   item_t       it;
   logic [31:0] exp_pc;
   logic [31:0] stale_addr;
   bit          stale;
   bit          started;
   bit          exp_req_pre;
   int unsigned fetch_n;
   int unsigned stall_n;
   int          checks = 0;
   int          errors = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      exp_pc     = PC_START;
      stale_addr = PC_START;
      stale      = 1'b0;
      started    = 1'b0;
      fetch_n    = 0;
      stall_n    = 0;
   endtask

   // Monitor: compares DUT outputs against the model and retires consumed instructions
   always @(negedge clk) begin
      exp_req_pre = started && (stale || q.size() < 2);
      check1("imem_req", imem_req, exp_req_pre);
      if (exp_req_pre) begin
         check32("imem_addr", imem_addr, stale ? stale_addr : exp_pc);
      end
      if (!reset) begin
         check32("reset_addr", imem_addr, PC_START);
         check32("reset_instr", instr, 32'd0);
         check32("reset_instr_pc", instr_pc, 32'd0);
      end
      check1("instr_valid", instr_valid, q.size() > 0);
`ifdef FETCH_PERF_CNT_EN
      check32("fetch_cnt", fetch_cnt, fetch_n);
      check32("stall_cnt", stall_cnt, stall_n);
`else
      check32("fetch_cnt", fetch_cnt, 32'd0);
      check32("stall_cnt", stall_cnt, 32'd0);
`endif
      if (q.size() > 0) begin
         if (stall) begin
            stall_n++;
         end else begin
            it = q.pop_front();
            check32("instr_pc", instr_pc, it.pc);
            check32("instr", instr, it.data);
            fetch_n++;
         end
      end
   end

   // Drive one cycle of inputs, then update the model with the effect of that edge
   task automatic step(input bit s, input bit r, input logic [31:0] rp, input bit a, input bit rs);
      stall       = s;
      redirect    = r;
      redirect_pc = rp;
      imem_ack    = a;
      reset       = rs;
      if (!rs) model_reset();
      @(posedge clk);
      #1;
      if (rs) begin
         if (r) begin
            if (exp_req_pre && a) begin
               stale = 1'b0;
            end else if (exp_req_pre && !stale) begin
               stale      = 1'b1;
               stale_addr = exp_pc;
            end
            q.delete();
            exp_pc = {rp[31:2], 2'b00};
         end else if (exp_req_pre && a) begin
            if (stale) begin
               stale = 1'b0;
            end else begin
               q.push_back(item_t'{pc: exp_pc, data: mem_f(exp_pc)});
               exp_pc = exp_pc + 32'd4;
            end
         end
         started = 1'b1;
      end
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 32'd0, 1, 0);

      // Zero-wait streaming from PC_START
      for (int i = 0; i < 6; i++) step(0, 0, 32'd0, 1, 1);
      // Stall three cycles with ack held, then release
      for (int i = 0; i < 3; i++) step(1, 0, 32'd0, 1, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 32'd0, 1, 1);
      // Redirect with request outstanding: stale ack discarded
      step(0, 1, 32'h0000_4003, 0, 1);
      for (int i = 0; i < 2; i++) step(0, 0, 32'd0, 0, 1);
      step(0, 0, 32'd0, 1, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 32'd0, 1, 1);
      // Redirect on the same edge as ack with stall
      step(1, 1, 32'h0000_5000, 1, 1);
      for (int i = 0; i < 2; i++) step(0, 0, 32'd0, 0, 1);
      // Address wrap at the top of memory
      step(0, 1, 32'hFFFF_FFFC, 1, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 32'd0, 1, 1);
      // Mid-transaction reset with ack still arriving
      step(0, 0, 32'd0, 1, 0);
      step(0, 0, 32'd0, 1, 0);
      step(0, 0, 32'd0, 1, 1);

      for (int i = 0; i < 4000; i++) begin
         logic [31:0] rp;
         rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 | $urandom_range(0, 7) : $urandom;
         step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, rp,
              $urandom_range(0, 1) == 1, $urandom_range(0, 199) != 0);
      end
      for (int i = 0; i < 4; i++) step(0, 0, 32'd0, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
